// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
//   Drives the Avalon-MM management port of a PLL reconfiguration controller.
//   One request carries the N, M and C0 counter words. The block then:
//     - writes mode, N, M, C0 and start;
//     - polls the status register until bit0 is set;
//     - waits for pll_locked to stay high for LOCK_STABLE cycles.
//   It ends with a one-cycle done pulse and a held error code.
//
// Ports
//   clk, rst             management clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; counter words latched on accept
//   req_n/req_m/req_c0   18-bit counter words {odd, bypass, lo[7:0], hi[7:0]}
//   mgmt_*               Avalon-MM master towards the reconfig controller
//   pll_locked           PLL lock, already synchronous to clk
//   busy                 sequence in progress (state != IDLE)
//   done                 one-cycle end-of-sequence pulse
//   err, err_code        0 none, 1 status poll timeout, 2 lock timeout;
//                        held until the next request is accepted
module pll_reconfig_seq #(
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [17:0] req_n,
  input  logic [17:0] req_m,
  input  logic [17:0] req_c0,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

  localparam logic [PW-1:0] POLL_MAX   = PW'(POLL_TIMEOUT);
  localparam logic [TW-1:0] LOCK_MAX   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C      = 6'd5;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_POLL = 2'd1;
  localparam logic [1:0] CODE_LOCK = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_N,
    WR_M,
    WR_C,
    WR_START,
    RD_STATUS,
    WAIT_LOCK,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [17:0]   n_q, n_d;
  logic [17:0]   m_q, m_d;
  logic [17:0]   c_q, c_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tot_q, tot_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  // Only the status bit of the read data is meaningful.
  logic unused_rdata;
  assign unused_rdata = ^mgmt_readdata[31:1];

  // Gated by rst so nothing can be accepted while reset is held.
  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign err       = err_q;
  assign err_code  = code_q;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    m_d            = m_q;
    c_d            = c_q;
    poll_d         = poll_q;
    tot_d          = tot_q;
    stab_d         = stab_q;
    err_d          = err_q;
    code_d         = code_q;
    mgmt_address   = '0;
    mgmt_read      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_writedata = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          n_d     = req_n;
          m_d     = req_m;
          c_d     = req_c0;
          err_d   = 1'b0;
          code_d  = CODE_NONE;
          state_d = WR_MODE;
        end
      end

      WR_MODE: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_MODE;
        mgmt_writedata = 32'd1;
        if (!mgmt_waitrequest) state_d = WR_N;
      end

      WR_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_N;
        mgmt_writedata = {14'b0, n_q};
        if (!mgmt_waitrequest) state_d = WR_M;
      end

      WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_M;
        mgmt_writedata = {14'b0, m_q};
        if (!mgmt_waitrequest) state_d = WR_C;
      end

      WR_C: begin
        // [22:18] selects the C counter; C0 is select 0.
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_C;
        mgmt_writedata = {9'b0, 5'd0, c_q};
        if (!mgmt_waitrequest) state_d = WR_START;
      end

      WR_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_START;
        mgmt_writedata = 32'd0;
        if (!mgmt_waitrequest) begin
          poll_d  = '0;
          state_d = RD_STATUS;
        end
      end

      RD_STATUS: begin
        // The timeout check comes first so the read strobe drops in the
        // very cycle the budget is exhausted, even mid-stall.
        if (poll_q == POLL_MAX) begin
          err_d   = 1'b1;
          code_d  = CODE_POLL;
          state_d = FINISH;
        end else begin
          mgmt_read    = 1'b1;
          mgmt_address = ADDR_STATUS;
          poll_d       = poll_q + 1'b1;
          if (!mgmt_waitrequest && mgmt_readdata[0]) begin
            tot_d   = '0;
            stab_d  = '0;
            state_d = WAIT_LOCK;
          end
        end
      end

      WAIT_LOCK: begin
        // Stable check outranks the timeout when both hit together.
        if (stab_q == STABLE_MAX) begin
          err_d   = 1'b0;
          code_d  = CODE_NONE;
          state_d = FINISH;
        end else if (tot_q == LOCK_MAX) begin
          err_d   = 1'b1;
          code_d  = CODE_LOCK;
          state_d = FINISH;
        end else begin
          tot_d  = tot_q + 1'b1;
          stab_d = pll_locked ? stab_q + 1'b1 : '0;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      poll_q  <= '0;
      tot_q   <= '0;
      stab_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c_q     <= c_d;
      poll_q  <= poll_d;
      tot_q   <= tot_d;
      stab_q  <= stab_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(mgmt_read && mgmt_write));

  a_write_hold: assert property (@(posedge clk) disable iff (rst)
    (mgmt_write && mgmt_waitrequest) |=>
      (mgmt_write && $stable(mgmt_address) && $stable(mgmt_writedata)));

endmodule

// File: tb/tb_pll_reconfig_seq.sv
`timescale 1ns/1ps
module tb_pll_reconfig_seq;

  localparam int unsigned PT = 16;
  localparam int unsigned LT = 200;
  localparam int unsigned LS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [17:0] req_n = '0, req_m = '0, req_c0 = '0;
  logic [5:0]  mgmt_address;
  logic        mgmt_read, mgmt_write;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  pll_reconfig_seq #(
    .POLL_TIMEOUT(PT),
    .LOCK_TIMEOUT(LT),
    .LOCK_STABLE (LS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_n           (req_n),
    .req_m           (req_m),
    .req_c0          (req_c0),
    .mgmt_address    (mgmt_address),
    .mgmt_read       (mgmt_read),
    .mgmt_write      (mgmt_write),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked      (pll_locked),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_code        (err_code)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // scenario knobs
  int stall_mode = 0;   // 0 none, 1 always 3, 2 random 0..3
  int ok_after   = 0;   // reads answering 0 before status bit0 = 1; -1 never
  int lock_mode  = 0;   // 0 high, 1 low, 2 glitch at 40, 3 random mostly high
  int rst_cnt    = 3;
  logic        drv_valid = 1'b0;
  logic [17:0] drv_n = '0, drv_m = '0, drv_c = '0;

  // slave
  bit in_xfer    = 0;
  int stall_left = 0;

  // reference model of one sequence, in terms of phases and cycle numbers
  bit          act        = 0;
  int          acc_c      = -1;
  int          finish_c   = -1;
  int          fin_code   = 0;
  int          wr_done    = 0;
  int          reads_done = 0;
  int          poll_start = -1;
  int          lock_start = -1;
  int          run        = 0;
  bit          held_err   = 0;
  logic [1:0]  held_code  = 2'd0;
  bit          after_rst  = 0;
  int          n_acc      = 0;
  logic [5:0]  exp_a [5];
  logic [31:0] exp_d [5];

  // observations
  logic [5:0]  log_a [$];
  logic [31:0] log_d [$];
  bit          log_w [$];
  int          obs_done_c = -1;
  int          n_done     = 0;
  logic [1:0]  obs_code   = 2'd0;
  logic        obs_err    = 1'b0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  function automatic int pick_stall();
    if (stall_mode == 1) return 3;
    if (stall_mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  task automatic step();
    bit          strobe, in_fin, ewr, erd, exp_ready, eerr;
    logic [1:0]  ecode;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;
    rst = (rst_cnt > 0);
    if (rst_cnt > 0) rst_cnt--;
    req_valid = drv_valid;
    req_n     = drv_n;
    req_m     = drv_m;
    req_c0    = drv_c;
    case (lock_mode)
      0:       pll_locked = 1'b1;
      1:       pll_locked = 1'b0;
      2:       pll_locked = !(lock_start >= 0 && cyc - lock_start == 40);
      default: pll_locked = ($urandom_range(0, 40) != 0);
    endcase
    #1;
    strobe = mgmt_write | mgmt_read;
    if (strobe) begin
      if (!in_xfer) begin
        stall_left = pick_stall();
        in_xfer = 1;
      end
      if (stall_left > 0) begin
        mgmt_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mgmt_waitrequest = 1'b0;
        in_xfer = 0;
      end
    end else begin
      in_xfer = 0;
      mgmt_waitrequest = (stall_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    rd = $urandom();
    rd[0] = (ok_after >= 0) && (reads_done >= ok_after);
    mgmt_readdata = rd;

    // expectations for this cycle
    exp_ready = !act && !rst;
    in_fin = act && (cyc == finish_c);
    ewr = act && !in_fin && (wr_done < 5);
    erd = 0;
    if (act && !in_fin && wr_done == 5 && lock_start < 0) begin
      if (cyc - poll_start >= int'(PT)) begin
        finish_c = cyc + 1;
        fin_code = 1;
      end else begin
        erd = 1;
      end
    end
    if (act && !in_fin && lock_start >= 0) begin
      if (run >= int'(LS)) begin
        finish_c = cyc + 1;
        fin_code = 0;
      end else if (cyc - lock_start >= int'(LT)) begin
        finish_c = cyc + 1;
        fin_code = 2;
      end
      run = pll_locked ? run + 1 : 0;
    end
    eerr  = in_fin ? (fin_code != 0) : held_err;
    ecode = in_fin ? 2'(fin_code) : held_code;

    chk("req_ready", req_ready, exp_ready);
    chk("busy", busy, act);
    chk("done", done, in_fin);
    chk("err", err, eerr);
    chk("err_code", err_code, ecode);
    chk("mgmt_write", mgmt_write, ewr);
    chk("mgmt_read", mgmt_read, erd);
    if (ewr) begin
      chk("wr_addr", mgmt_address, exp_a[wr_done]);
      chk("wr_data", mgmt_writedata, exp_d[wr_done]);
    end
    if (erd) chk("rd_addr", mgmt_address, 32'd1);
    if (after_rst) begin
      chk("rst_addr", mgmt_address, 32'd0);
      chk("rst_wdata", mgmt_writedata, 32'd0);
    end

    // observations
    if (strobe && !mgmt_waitrequest) begin
      log_a.push_back(mgmt_address);
      log_d.push_back(mgmt_writedata);
      log_w.push_back(mgmt_write);
    end
    if (done) begin
      obs_done_c = cyc;
      obs_code   = err_code;
      obs_err    = err;
      n_done++;
    end

    // model advance
    if ((ewr || erd) && !mgmt_waitrequest) begin
      if (ewr) begin
        wr_done++;
        if (wr_done == 5) poll_start = cyc + 1;
      end else begin
        reads_done++;
        if (rd[0]) lock_start = cyc + 1;
      end
    end
    if (in_fin) begin
      held_err  = (fin_code != 0);
      held_code = 2'(fin_code);
      act = 0;
    end
    if (exp_ready && req_valid) begin
      act = 1; acc_c = cyc; finish_c = -1;
      held_err = 0; held_code = 2'd0;
      wr_done = 0; reads_done = 0; poll_start = -1; lock_start = -1; run = 0;
      exp_a[0] = 6'd0; exp_d[0] = 32'd1;
      exp_a[1] = 6'd3; exp_d[1] = {14'b0, req_n};
      exp_a[2] = 6'd4; exp_d[2] = {14'b0, req_m};
      exp_a[3] = 6'd5; exp_d[3] = {9'b0, 5'd0, req_c0};
      exp_a[4] = 6'd2; exp_d[4] = 32'd0;
      n_acc++;
    end
    if (rst) begin
      act = 0; finish_c = -1; lock_start = -1;
      held_err = 0; held_code = 2'd0;
    end
    after_rst = rst;
  endtask

  task automatic run_req(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c);
    int a0, t;
    a0 = n_acc;
    drv_n = n; drv_m = m; drv_c = c; drv_valid = 1'b1;
    t = 0;
    while (n_acc == a0 && t < 20) begin step(); t++; end
    drv_valid = 1'b0;
    chk("accept_bound", n_acc - a0, 32'd1);
    t = 0;
    while (act && t < 3000) begin step(); t++; end
    chk("done_bound", act, 32'd0);
  endtask

  function automatic logic [5:0] nom_addr(int i);
    case (i)
      0: return 6'd0;
      1: return 6'd3;
      2: return 6'd4;
      3: return 6'd5;
      4: return 6'd2;
      default: return 6'd1;
    endcase
  endfunction

  function automatic logic [31:0] nom_data(int i);
    case (i)
      0: return 32'd1;
      1: return 32'h10000;
      2: return 32'h00404;
      3: return 32'h00202;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_nominal_log(input string tag);
    chk({tag, "_xfers"}, log_a.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_a.size()) begin
        chk({tag, "_addr"}, log_a[i], nom_addr(i));
        chk({tag, "_is_wr"}, log_w[i], (i < 5));
        if (i < 5) chk({tag, "_data"}, log_d[i], nom_data(i));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, t, nd0, first_done;
    repeat (5) step();

    // nominal
    stall_mode = 0; ok_after = 0; lock_mode = 0;
    log_a.delete(); log_d.delete(); log_w.delete();
    run_req(18'h10000, 18'h00404, 18'h00202);
    chk("nom_latency", obs_done_c - acc_c, 32'd72);
    chk("nom_err", obs_err, 32'd0);
    chk("nom_code", obs_code, 32'd0);
    check_nominal_log("nom");
    repeat (2) step();

    // waitrequest stalls of 3 cycles on every transfer
    stall_mode = 1;
    log_a.delete(); log_d.delete(); log_w.delete();
    run_req(18'h10000, 18'h00404, 18'h00202);
    chk("stall_latency", obs_done_c - acc_c, 32'd90);
    check_nominal_log("stall");
    stall_mode = 0;
    step();

    // status poll timeout
    ok_after = -1;
    log_a.delete(); log_d.delete(); log_w.delete();
    run_req(18'h3ffff, 18'h00001, 18'h15a5a);
    chk("poll_latency", obs_done_c - acc_c, 32'd23);
    chk("poll_err", obs_err, 32'd1);
    chk("poll_code", obs_code, 32'd1);
    chk("poll_xfers", log_a.size(), 32'd21);
    step();
    chk("poll_idle", req_ready, 32'd1);

    // lock glitch after 40 high cycles
    ok_after = 0; lock_mode = 2;
    run_req(18'h00101, 18'h20808, 18'h00303);
    chk("glitch_latency", obs_done_c - acc_c, 32'd113);
    chk("glitch_code", obs_code, 32'd0);
    step();

    // lock never arrives
    lock_mode = 1;
    run_req(18'h00101, 18'h20808, 18'h00303);
    chk("lockto_latency", obs_done_c - acc_c, 32'd208);
    chk("lockto_err", obs_err, 32'd1);
    chk("lockto_code", obs_code, 32'd2);
    lock_mode = 0;
    step();

    // reset asserted while WR_M is on the bus
    log_a.delete(); log_d.delete(); log_w.delete();
    nd0 = n_done;
    drv_n = 18'h0aaaa; drv_m = 18'h15555; drv_c = 18'h00f0f; drv_valid = 1'b1;
    a0 = n_acc; t = 0;
    while (n_acc == a0 && t < 20) begin step(); t++; end
    drv_valid = 1'b0;
    t = 0;
    while (wr_done < 2 && t < 20) begin step(); t++; end
    rst_cnt = 2;
    repeat (12) step();
    chk("rst_no_done", n_done - nd0, 32'd0);
    chk("rst_xfers", log_a.size(), 32'd3);

    // back-to-back: a failing request followed immediately by another
    ok_after = -1;
    drv_n = 18'h01234; drv_m = 18'h04321; drv_c = 18'h00011; drv_valid = 1'b1;
    a0 = n_acc; t = 0;
    while (n_acc == a0 && t < 20) begin step(); t++; end
    drv_n = 18'h10000; drv_m = 18'h00404; drv_c = 18'h00202;
    t = 0;
    while (n_acc < a0 + 2 && t < 200) begin step(); t++; end
    first_done = obs_done_c;
    chk("b2b_accepts", n_acc - a0, 32'd2);
    chk("b2b_gap", acc_c - first_done, 32'd1);
    chk("b2b_first_code", obs_code, 32'd1);
    ok_after = 0; drv_valid = 1'b0;
    step();
    chk("b2b_err_cleared", err, 32'd0);
    t = 0;
    while (act && t < 3000) begin step(); t++; end
    chk("b2b_second_code", obs_code, 32'd0);
    chk("b2b_second_err", obs_err, 32'd0);

    // randomized requests
    for (int i = 0; i < 25; i++) begin
      stall_mode = int'($urandom_range(0, 2));
      ok_after   = int'($urandom_range(0, 5)) - 1;
      lock_mode  = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) step();
      run_req(18'($urandom()), 18'($urandom()), 18'($urandom()));
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
